// File: rtl/intr_ctrl_pkg.sv
// Shared register indices, bit positions and reset constants for the
// interrupt controller.
package intr_ctrl_pkg;

   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_CTRL        = 3'd4,
      REG_PENDING     = 3'd5,
      REG_PRESCALE    = 3'd6,
      REG_RESERVED    = 3'd7
   } reg_idx_e;

   localparam int unsigned CTRL_TIMER_EN_BIT = 0;
   localparam int unsigned CTRL_EXT_EN_BIT   = 1;
   localparam int unsigned PEND_EXT_BIT      = 1;

   localparam logic [63:0] MTIMECMP_RST = '1;

endpackage

// File: rtl/intr_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge detector.
module intr_sync_edge (
   input  logic clk,
   input  logic rstn,
   input  logic async_in,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta   <= async_in;
         sync   <= meta;
         sync_q <= sync;
      end
   end

   assign rise = sync & ~sync_q;

endmodule

// File: rtl/intr_ctrl.sv
// Machine timer plus external interrupt controller behind a simple
// one-cycle request/ack register bus.
module intr_ctrl
   import intr_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   input  logic        ext_irq_in,
   output logic        ext_intr,
   output logic        timer_intr
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        timer_en;
   logic        ext_en;
   logic        ext_pend;
   logic [15:0] prescale;
   logic [15:0] pre_cnt;
   logic        ext_rise;
   logic        tick;
   logic        wr;
   reg_idx_e    idx;
   logic [31:0] rd_mux;

   intr_sync_edge u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .async_in (ext_irq_in),
      .rise     (ext_rise)
   );

   assign idx  = reg_idx_e'(addr);
   assign wr   = req & we;
   assign tick = (pre_cnt == prescale);

   always_comb begin
      rd_mux = '0;
      case (idx)
         REG_MTIME_LO:    rd_mux = mtime[31:0];
         REG_MTIME_HI:    rd_mux = mtime[63:32];
         REG_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
         REG_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
         REG_CTRL: begin
            rd_mux[CTRL_TIMER_EN_BIT] = timer_en;
            rd_mux[CTRL_EXT_EN_BIT]   = ext_en;
         end
         REG_PENDING:     rd_mux[PEND_EXT_BIT] = ext_pend;
         REG_PRESCALE:    rd_mux[15:0] = prescale;
         default:         rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ack        <= 1'b0;
         rdata      <= '0;
         mtime      <= '0;
         mtimecmp   <= MTIMECMP_RST;
         timer_en   <= 1'b0;
         ext_en     <= 1'b0;
         ext_pend   <= 1'b0;
         prescale   <= '0;
         pre_cnt    <= '0;
         timer_intr <= 1'b0;
         ext_intr   <= 1'b0;
      end else begin
         ack   <= req;
         rdata <= (req && !we) ? rd_mux : '0;

         if (wr && idx == REG_PRESCALE) begin
            prescale <= wdata[15:0];
            pre_cnt  <= '0;
         end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
         end

         // A bus write to either half replaces that half only and suppresses
         // the tick for this cycle, so no carry crosses halves.
         if (wr && idx == REG_MTIME_LO) begin
            mtime[31:0] <= wdata;
         end else if (wr && idx == REG_MTIME_HI) begin
            mtime[63:32] <= wdata;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         if (wr && idx == REG_MTIMECMP_LO) mtimecmp[31:0]  <= wdata;
         if (wr && idx == REG_MTIMECMP_HI) mtimecmp[63:32] <= wdata;

         if (wr && idx == REG_CTRL) begin
            timer_en <= wdata[CTRL_TIMER_EN_BIT];
            ext_en   <= wdata[CTRL_EXT_EN_BIT];
         end

         if (ext_rise) begin
            ext_pend <= 1'b1;
         end else if (wr && idx == REG_PENDING && wdata[PEND_EXT_BIT]) begin
            ext_pend <= 1'b0;
         end

         timer_intr <= timer_en && (mtime >= mtimecmp);
         ext_intr   <= ext_en && ext_pend;
      end
   end

endmodule
